// File: rtl/coherence_pkg.sv
// Shared coherence definitions used by the bus request unit and the bus
// controller: bus operation encoding and L2 hit/miss status codes.
package coherence_pkg;

  // Snooping bus operations as they appear on the request bus
  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_UPGR = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_NON  = 2'b11
  } bus_op_e;

  // L2 lookup result reported by the bus controller
  typedef enum logic [1:0] {
    L2_NONE = 2'b00,
    L2_MISS = 2'b01,
    L2_HIT  = 2'b10
  } l2_code_e;

endpackage

// File: rtl/bus_request_unit.sv
// Bus request unit: takes one coherence request from the L1, holds it on the
// bus until the controller grants and a data source (peer or L2) answers, then
// hands a one-cycle completion back to the L1. A flush aborts an outstanding
// request.
// Optional build macro BUS_REQ_TIMEOUT_EN: when defined, a request that sits
// in REQ for TIMEOUT_CYCLES cycles without completing is aborted.
module bus_request_unit
  import coherence_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        l1_req_valid,
  output logic        l1_req_ready,
  input  logic [1:0]  l1_req_op,
  input  logic [31:0] l1_req_addr,
  input  logic [31:0] l1_req_wdata,
  input  logic [6:0]  l1_req_opcode,
  input  logic        flush,
  output logic        l1_resp_valid,
  output logic [31:0] l1_resp_data,
  output logic        l1_resp_from_peer,
  output logic        l1_resp_abort,
  output logic        req_core,
  output logic [1:0]  bus_operation_out,
  output logic [31:0] bus_address_out,
  output logic [31:0] data_to_L2,
  output logic [6:0]  opcode_out,
  input  logic        grant_core,
  input  logic [31:0] bus_data_in,
  input  logic        cache_hit_in,
  input  logic [1:0]  cache_hit_L2
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      r_state;
  logic        r_ready;
  logic        r_req_core;
  bus_op_e     r_bus_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [6:0]  r_opcode;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic        r_from_peer;
  logic        r_abort;

  logic w_accept;
  logic w_upgr;
  logic w_complete;
  logic w_timeout;

  // BusNoN never leaves IDLE, and a flush in IDLE blocks acceptance
  assign w_accept   = l1_req_valid && r_ready && !flush &&
                      (bus_op_e'(l1_req_op) != BUS_NON);
  assign w_upgr     = (r_bus_op == BUS_UPGR);
  // An upgrade needs no data, so the grant alone completes it
  assign w_complete = grant_core &&
                      (w_upgr || cache_hit_in || (cache_hit_L2 == L2_HIT));

`ifdef BUS_REQ_TIMEOUT_EN
  logic [31:0] r_cnt;
  assign w_timeout = (r_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
  // Without the timeout the parameter only keeps the interface uniform
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // Request FSM with all outputs registered; bus outputs double as the request latches
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b1;
      r_req_core   <= 1'b0;
      r_bus_op     <= BUS_NON;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_opcode     <= 7'd0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'd0;
      r_from_peer  <= 1'b0;
      r_abort      <= 1'b0;
`ifdef BUS_REQ_TIMEOUT_EN
      r_cnt        <= 32'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_REQ;
            r_ready    <= 1'b0;
            r_req_core <= 1'b1;
            r_bus_op   <= bus_op_e'(l1_req_op);
            r_addr     <= l1_req_addr;
            r_wdata    <= l1_req_wdata;
            r_opcode   <= l1_req_opcode;
`ifdef BUS_REQ_TIMEOUT_EN
            r_cnt      <= 32'd0;
`endif
          end
        end
        S_REQ: begin
          if (flush || w_complete || w_timeout) begin
            r_state      <= S_RESP;
            r_req_core   <= 1'b0;
            r_bus_op     <= BUS_NON;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_opcode     <= 7'd0;
            r_resp_valid <= 1'b1;
            if (flush || !w_complete) begin
              r_resp_data <= 32'd0;
              r_from_peer <= 1'b0;
              r_abort     <= 1'b1;
            end else begin
              r_resp_data <= w_upgr ? 32'd0 : bus_data_in;
              r_from_peer <= !w_upgr && cache_hit_in;
              r_abort     <= 1'b0;
            end
          end
`ifdef BUS_REQ_TIMEOUT_EN
          else begin
            r_cnt <= r_cnt + 32'd1;
          end
`endif
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_ready      <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_data  <= 32'd0;
          r_from_peer  <= 1'b0;
          r_abort      <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign l1_req_ready      = r_ready;
  assign l1_resp_valid     = r_resp_valid;
  assign l1_resp_data      = r_resp_data;
  assign l1_resp_from_peer = r_from_peer;
  assign l1_resp_abort     = r_abort;
  assign req_core          = r_req_core;
  assign bus_operation_out = r_bus_op;
  assign bus_address_out   = r_addr;
  assign data_to_L2        = r_wdata;
  assign opcode_out        = r_opcode;

endmodule

// File: tb/tb_bus_request_unit.sv
// Testbench for bus_request_unit: directed requests with hand-computed
// responses queued in a scoreboard and checked by an independent monitor.
// Honours BUS_REQ_TIMEOUT_EN the same way the design does.
module tb_bus_request_unit;

  logic        clk;
  logic        reset;
  logic        l1_req_valid;
  logic        l1_req_ready;
  logic [1:0]  l1_req_op;
  logic [31:0] l1_req_addr;
  logic [31:0] l1_req_wdata;
  logic [6:0]  l1_req_opcode;
  logic        flush;
  logic        l1_resp_valid;
  logic [31:0] l1_resp_data;
  logic        l1_resp_from_peer;
  logic        l1_resp_abort;
  logic        req_core;
  logic [1:0]  bus_operation_out;
  logic [31:0] bus_address_out;
  logic [31:0] data_to_L2;
  logic [6:0]  opcode_out;
  logic        grant_core;
  logic [31:0] bus_data_in;
  logic        cache_hit_in;
  logic [1:0]  cache_hit_L2;

  typedef struct {
    logic [31:0] data;
    logic        peer;
    logic        abort;
  } resp_t;

  resp_t expQ[$];
  int    vectors;
  int    miscompares;

  logic [1:0]  lastOp;
  logic [31:0] lastAddr;
  logic [31:0] lastWdata;
  logic [6:0]  lastOpcode;

  int reqCycles;
  int latency;

  bus_request_unit #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .l1_req_valid     (l1_req_valid),
    .l1_req_ready     (l1_req_ready),
    .l1_req_op        (l1_req_op),
    .l1_req_addr      (l1_req_addr),
    .l1_req_wdata     (l1_req_wdata),
    .l1_req_opcode    (l1_req_opcode),
    .flush            (flush),
    .l1_resp_valid    (l1_resp_valid),
    .l1_resp_data     (l1_resp_data),
    .l1_resp_from_peer(l1_resp_from_peer),
    .l1_resp_abort    (l1_resp_abort),
    .req_core         (req_core),
    .bus_operation_out(bus_operation_out),
    .bus_address_out  (bus_address_out),
    .data_to_L2       (data_to_L2),
    .opcode_out       (opcode_out),
    .grant_core       (grant_core),
    .bus_data_in      (bus_data_in),
    .cache_hit_in     (cache_hit_in),
    .cache_hit_L2     (cache_hit_L2)
  );

  // 100 MHz free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Every response the DUT presents must match the oldest queued expectation
  always @(negedge clk) begin
    if (l1_resp_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_resp: got data 0x%08h abort %0b, expected no response",
                 l1_resp_data, l1_resp_abort);
      end else begin
        resp_t e;
        e = expQ.pop_front();
        checkOutput("resp_data", l1_resp_data, e.data);
        checkOutput("resp_from_peer", 32'(l1_resp_from_peer), 32'(e.peer));
        checkOutput("resp_abort", 32'(l1_resp_abort), 32'(e.abort));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns just after the accepting edge
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [6:0] opcode);
    l1_req_valid  = 1'b1;
    l1_req_op     = op;
    l1_req_addr   = addr;
    l1_req_wdata  = wdata;
    l1_req_opcode = opcode;
    lastOp        = op;
    lastAddr      = addr;
    lastWdata     = wdata;
    lastOpcode    = opcode;
    @(negedge clk);
    checkOutput("ready_in_idle", 32'(l1_req_ready), 32'd1);
    tick();
    l1_req_valid = 1'b0;
  endtask

  // Drive the bus side cycle by cycle after acceptance until a response shows
  task automatic waitResponse(input int grantDelay, input int hitAt, input int flushAt,
                              input int budget, output int nReq, output int lat);
    nReq = 0;
    lat  = -1;
    grant_core   = (grantDelay <= 0);
    cache_hit_L2 = (hitAt <= 0) ? 2'b10 : 2'b01;
    flush        = (flushAt == 0);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (l1_resp_valid === 1'b1) begin
        lat = c + 1;
        checkOutput("req_core_in_resp", 32'(req_core), 32'd0);
        checkOutput("bus_op_in_resp", 32'(bus_operation_out), 32'd3);
        checkOutput("addr_in_resp", bus_address_out, 32'd0);
        break;
      end
      if (req_core === 1'b1) begin
        nReq++;
        checkOutput("bus_op_in_req", 32'(bus_operation_out), 32'(lastOp));
        checkOutput("addr_in_req", bus_address_out, lastAddr);
        checkOutput("wdata_in_req", data_to_L2, lastWdata);
        checkOutput("opcode_in_req", 32'(opcode_out), 32'(lastOpcode));
      end
      tick();
      grant_core   = (c + 1 >= grantDelay);
      cache_hit_L2 = (c + 1 >= hitAt) ? 2'b10 : 2'b01;
      flush        = (c + 1 == flushAt);
    end
    if (lat > 0) tick();
    flush        = 1'b0;
    grant_core   = 1'b0;
    cache_hit_L2 = 2'b00;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    l1_req_valid  = 1'b0;
    l1_req_op     = 2'b00;
    l1_req_addr   = 32'd0;
    l1_req_wdata  = 32'd0;
    l1_req_opcode = 7'd0;
    flush         = 1'b0;
    grant_core    = 1'b0;
    bus_data_in   = 32'd0;
    cache_hit_in  = 1'b0;
    cache_hit_L2  = 2'b00;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_ready", 32'(l1_req_ready), 32'd1);
    checkOutput("rst_req_core", 32'(req_core), 32'd0);
    checkOutput("rst_bus_op", 32'(bus_operation_out), 32'd3);
    checkOutput("rst_addr", bus_address_out, 32'd0);
    checkOutput("rst_resp_valid", 32'(l1_resp_valid), 32'd0);
    tick();

    // BusRd, immediate grant with peer hit
    cache_hit_in = 1'b1;
    bus_data_in  = 32'hDEAD_BEEF;
    expQ.push_back('{data: 32'hDEAD_BEEF, peer: 1'b1, abort: 1'b0});
    applyStimulus(2'b00, 32'h0000_0100, 32'h0000_0055, 7'h11);
    waitResponse(0, 99, -1, 20, reqCycles, latency);
    checkOutput("rd_req_cycles", 32'(reqCycles), 32'd1);
    checkOutput("rd_latency", 32'(latency), 32'd2);

    // BusRdX, grant withheld three cycles, L2 supplies data
    cache_hit_in = 1'b0;
    bus_data_in  = 32'h1234_5678;
    expQ.push_back('{data: 32'h1234_5678, peer: 1'b0, abort: 1'b0});
    applyStimulus(2'b10, 32'h0000_0200, 32'hA5A5_0001, 7'h22);
    waitResponse(3, 0, -1, 20, reqCycles, latency);
    checkOutput("rdx_req_cycles", 32'(reqCycles), 32'd4);
    checkOutput("rdx_latency", 32'(latency), 32'd5);

    // BusUpgr returns no data even with a peer hit; flush during RESP is ignored
    cache_hit_in = 1'b1;
    bus_data_in  = 32'hAAAA_5555;
    expQ.push_back('{data: 32'd0, peer: 1'b0, abort: 1'b0});
    applyStimulus(2'b01, 32'h0000_0300, 32'h0000_0777, 7'h33);
    waitResponse(0, 99, 1, 20, reqCycles, latency);
    checkOutput("upgr_req_cycles", 32'(reqCycles), 32'd1);
    checkOutput("upgr_latency", 32'(latency), 32'd2);

    // Flush in the second REQ cycle coincides with completion and wins
    cache_hit_in = 1'b1;
    bus_data_in  = 32'h0BAD_F00D;
    expQ.push_back('{data: 32'd0, peer: 1'b0, abort: 1'b1});
    applyStimulus(2'b00, 32'h0000_0400, 32'h0000_0001, 7'h44);
    waitResponse(1, 99, 1, 20, reqCycles, latency);
    checkOutput("flush_req_cycles", 32'(reqCycles), 32'd2);
    checkOutput("flush_latency", 32'(latency), 32'd3);

    // Granted but L2 misses with no peer: wait until L2 hits
    cache_hit_in = 1'b0;
    bus_data_in  = 32'hCAFE_F00D;
    expQ.push_back('{data: 32'hCAFE_F00D, peer: 1'b0, abort: 1'b0});
    applyStimulus(2'b00, 32'h0000_0500, 32'h0000_0002, 7'h55);
    waitResponse(0, 3, -1, 20, reqCycles, latency);
    checkOutput("miss_req_cycles", 32'(reqCycles), 32'd4);
    checkOutput("miss_latency", 32'(latency), 32'd5);

    // BusNoN is not accepted
    applyStimulus(2'b11, 32'h0000_0600, 32'h0000_0003, 7'h66);
    @(negedge clk);
    checkOutput("non_req_core", 32'(req_core), 32'd0);
    checkOutput("non_ready", 32'(l1_req_ready), 32'd1);
    tick();

    // Flush in IDLE blocks acceptance
    flush        = 1'b1;
    l1_req_valid = 1'b1;
    l1_req_op    = 2'b00;
    l1_req_addr  = 32'h0000_0680;
    tick();
    flush        = 1'b0;
    l1_req_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_flush_req_core", 32'(req_core), 32'd0);
    checkOutput("idle_flush_ready", 32'(l1_req_ready), 32'd1);
    tick();

    // Reset while in REQ drops the request silently
    grant_core = 1'b0;
    applyStimulus(2'b10, 32'h0000_0700, 32'h0000_0004, 7'h77);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstreq_req_core", 32'(req_core), 32'd0);
    checkOutput("rstreq_bus_op", 32'(bus_operation_out), 32'd3);
    checkOutput("rstreq_ready", 32'(l1_req_ready), 32'd1);
    checkOutput("rstreq_resp_valid", 32'(l1_resp_valid), 32'd0);
    tick();

    // Grant never arrives
    cache_hit_in = 1'b0;
`ifdef BUS_REQ_TIMEOUT_EN
    expQ.push_back('{data: 32'd0, peer: 1'b0, abort: 1'b1});
    applyStimulus(2'b00, 32'h0000_0800, 32'h0000_0005, 7'h08);
    waitResponse(1000, 1000, -1, 30, reqCycles, latency);
    checkOutput("timeout_req_cycles", 32'(reqCycles), 32'd8);
    checkOutput("timeout_latency", 32'(latency), 32'd9);
`else
    applyStimulus(2'b00, 32'h0000_0800, 32'h0000_0005, 7'h08);
    waitResponse(1000, 1000, -1, 100, reqCycles, latency);
    checkOutput("noto_req_cycles", 32'(reqCycles), 32'd100);
    checkOutput("noto_no_resp", 32'(latency), 32'hFFFF_FFFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("noto_rst_req_core", 32'(req_core), 32'd0);
    checkOutput("noto_rst_ready", 32'(l1_req_ready), 32'd1);
    tick();
`endif

    tick();
    tick();
    checkOutput("pending_resp", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_request_unit.md
BUS_REQUEST_UNIT -- requirements
Module: bus_request_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning max REQ-state cycles before abort (only with the timeout macro enabled).
REQ-002 SHALL have the single clock `clk`; reset is synchronous and active-high, port `reset`.
REQ-003 `clk`  in  1  rising-edge clock.
REQ-004 `reset`  in  1  synchronous active-high reset.
REQ-005 `l1_req_valid`  in  1  L1 presents a coherence request.
REQ-006 `l1_req_ready`  out  1  unit accepts request (high only in IDLE).
REQ-007 `l1_req_op`  in  2  00 BusRd, 01 BusUpgr, 10 BusRdX, 11 BusNoN.
REQ-008 `l1_req_addr` in 32, `l1_req_wdata` in 32, `l1_req_opcode` in 7  request payload.
REQ-009 `flush`  in  1  abort any outstanding request.
REQ-010 `l1_resp_valid` out 1, `l1_resp_data` out 32, `l1_resp_from_peer` out 1, `l1_resp_abort` out 1  completion to L1.
REQ-011 `req_core` out 1, `bus_operation_out` out 2, `bus_address_out` out 32, `data_to_L2` out 32, `opcode_out` out 7  request to bus controller.
REQ-012 `grant_core` in 1, `bus_data_in` in 32, `cache_hit_in` in 1, `cache_hit_L2` in 2 (10 hit, 01 miss)  bus controller response.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, RESP.
REQ-014 IDLE: accept when l1_req_valid && l1_req_ready && l1_req_op!=11; latch op/addr/wdata/opcode; next REQ. op==11 SHALL be ignored (stay IDLE).
REQ-015 REQ: req_core=1, bus outputs driven from latched registers, stable until leaving REQ.
REQ-016 REQ completion: grant_core && (op==01 || cache_hit_in || cache_hit_L2==10) SHALL capture bus_data_in (peer hit) else bus_data_in (L2 data via bus); set from_peer=cache_hit_in; next RESP.
REQ-017 BusUpgr completion SHALL return l1_resp_data=0, from_peer=0.
REQ-018 grant_core low, or cache_hit_L2==01 with no peer hit: remain in REQ, outputs unchanged.
REQ-019 RESP: l1_resp_valid=1 for exactly one cycle, then IDLE; latency accept->resp_valid minimum 2 cycles.
REQ-020 flush in REQ SHALL go to RESP with l1_resp_abort=1, l1_resp_valid=1, data 0; flush in IDLE blocks acceptance that cycle; flush in RESP has no effect.
REQ-021 Outside REQ: req_core=0, bus_operation_out=11, address/data/opcode outputs 0.
REQ-022 Completion and flush in same REQ cycle: flush wins (abort).

Reset
REQ-023 reset SHALL force IDLE, clear latches, timeout counter 0; all outputs 0 except bus_operation_out=11 and l1_req_ready=1 in the cycle after reset.
REQ-024 reset mid-REQ or mid-RESP SHALL drop the transaction with no l1_resp_valid.

Configuration
REQ-025 Macro BUS_REQ_TIMEOUT_EN: defined -> counter increments each REQ cycle, cleared on entry; reaching TIMEOUT_CYCLES-1 without completion SHALL exit to RESP with l1_resp_abort=1.
REQ-026 Undefined -> no counter, REQ waits indefinitely; TIMEOUT_CYCLES unused.

Structure
REQ-027 Bus-op encoding enum (BUS_RD, BUS_UPGR, BUS_RDX, BUS_NON) and L2 hit codes SHALL reside in shared package coherence_pkg, also used by the bus controller.
REQ-028 FSM state enum local to module; no sub-module required.

Verification
REQ-029 BusRd 0x0000_0100, grant=1, cache_hit_in=1, bus_data_in=0xDEAD_BEEF -> resp_valid 1 cycle, data 0xDEAD_BEEF, from_peer=1.
REQ-030 BusRdX 0x200, grant=0 for 3 cycles then 1 with cache_hit_L2=10, data 0x1234_5678 -> req_core held 4 cycles, resp data 0x1234_5678, from_peer=0.
REQ-031 BusUpgr 0x300, grant=1 -> resp after 2 cycles, data 0, bus_operation_out=01 during REQ only.
REQ-032 flush asserted in 2nd REQ cycle with cache_hit_in=1 -> abort=1, data 0.
REQ-033 BUS_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, grant=0 -> abort response after 8 REQ cycles; without macro, no response after 100 cycles.
REQ-034 reset in REQ -> next cycle req_core=0, op=11, ready=1, no resp_valid.
